// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default sizes for the PWM ramp controller slice.
package pwm_ctrl_pkg;

    localparam int unsigned PWM_CH = 8;
    localparam int unsigned PWM_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SCAN,
        COMMIT
    } pwm_ctrl_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Host-write handshake plus duty/counter outputs between the ramp controller and its users.
interface pwm_ramp_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned CH = PWM_CH,
    parameter int unsigned DW = PWM_DW
);
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

    logic               enable;
    logic               wr_valid;
    logic               wr_ready;
    logic [CW-1:0]      wr_ch;
    logic [DW-1:0]      wr_target;
    logic [DW-1:0]      cnt;
    logic [CH*DW-1:0]   duty_flat;
    logic               duty_load;
    logic               all_settled;

    modport master (
        output enable, wr_valid, wr_ch, wr_target,
        input  wr_ready, cnt, duty_flat, duty_load, all_settled
    );

    modport slave (
        input  enable, wr_valid, wr_ch, wr_target,
        output wr_ready, cnt, duty_flat, duty_load, all_settled
    );

endinterface

// File: rtl/pwm_ramp_step.sv
// One clamped ramp step: moves cur toward tgt by at most step, never overshooting.
module pwm_ramp_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] tgt,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] nxt
);

    logic [DW-1:0] diff;

    always_comb begin
        diff = '0;
        nxt  = cur;
        if (cur < tgt) begin
            diff = tgt - cur;
            nxt  = cur + ((diff < step) ? diff : step);
        end else if (cur > tgt) begin
            diff = cur - tgt;
            nxt  = cur - ((diff < step) ? diff : step);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start controller: shared period counter, per-channel targets, and a periodic
// one-channel-per-cycle ramp scan whose result is committed to the generator with a strobe.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned CH       = PWM_CH,
    parameter int unsigned DW       = PWM_DW,
    parameter int unsigned RAMP_DIV = 4,
    parameter int unsigned STEP     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_ramp_ctrl_if.slave  bus
);

    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned DIVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [DW-1:0]   CNT_MAX  = {DW{1'b1}};
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RAMP_DIV - 1);
    localparam logic [CW-1:0]   CH_LAST  = CW'(CH - 1);
    localparam logic [DW-1:0]   STEP_W   = DW'(STEP);

    pwm_ctrl_state_t state_q, state_d;

    logic [DW-1:0]      cnt_q, cnt_d;
    logic [DIVW-1:0]    div_q, div_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [DW-1:0]      cur_q [CH];
    logic [DW-1:0]      tgt_q [CH];
    logic [CH*DW-1:0]   duty_q;
    logic [CH*DW-1:0]   cur_flat;
    logic               load_q;
    logic               settled_q;

    logic               wrap;
    logic               cnt_run;
    logic               scan_en;
    logic               commit;
    logic               stop;
    logic               wr_ready;
    logic               wr_fire;
    logic               all_eq;
    logic [DW-1:0]      step_nxt;

    assign wrap    = (state_q == RUN) && (cnt_q == CNT_MAX);
    assign wr_fire = bus.wr_valid && wr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped enable wins over every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                if (!bus.enable)                     state_d = IDLE;
                else if (wrap && (div_q == DIV_LAST)) state_d = SCAN;
            end
            SCAN: begin
                if (!bus.enable)           state_d = IDLE;
                else if (ch_q == CH_LAST)  state_d = COMMIT;
            end
            COMMIT: begin
                if (!bus.enable) state_d = IDLE;
                else             state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        cnt_run  = 1'b0;
        scan_en  = 1'b0;
        commit   = 1'b0;
        wr_ready = 1'b1;
        case (state_q)
            IDLE: ;
            RUN: begin
                cnt_run = 1'b1;
            end
            SCAN: begin
                cnt_run  = 1'b1;
                scan_en  = 1'b1;
                wr_ready = 1'b0;
            end
            COMMIT: begin
                cnt_run = 1'b1;
                commit  = 1'b1;
            end
            default: ;
        endcase
        stop = (state_q != IDLE) && !bus.enable;
    end

    always_comb begin
        cnt_d = '0;
        div_d = '0;
        ch_d  = '0;
        if (!stop) begin
            if (cnt_run) cnt_d = cnt_q + 1'b1;
            div_d = div_q;
            if (wrap) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (scan_en && (ch_q != CH_LAST)) ch_d = ch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
            ch_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            ch_q  <= ch_d;
        end
    end

    pwm_ramp_step #(
        .DW (DW)
    ) u_step (
        .cur  (cur_q[ch_q]),
        .tgt  (tgt_q[ch_q]),
        .step (STEP_W),
        .nxt  (step_nxt)
    );

    // Reset or enable drop throws away any partially scanned values.
    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            for (int k = 0; k < CH; k++) cur_q[k] <= '0;
        end else if (scan_en) begin
            cur_q[ch_q] <= step_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) tgt_q[k] <= '0;
        end else if (wr_fire && ({1'b0, bus.wr_ch} < (CW+1)'(CH))) begin
            tgt_q[bus.wr_ch] <= bus.wr_target;
        end
    end

    always_comb begin
        cur_flat = '0;
        all_eq   = 1'b1;
        for (int k = 0; k < CH; k++) begin
            cur_flat[k*DW +: DW] = cur_q[k];
            if (duty_q[k*DW +: DW] != tgt_q[k]) all_eq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q    <= '0;
            load_q    <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            settled_q <= all_eq;
            if (stop) begin
                duty_q <= '0;
                load_q <= 1'b1;
            end else if (commit) begin
                duty_q <= cur_flat;
                load_q <= 1'b1;
            end else begin
                load_q <= 1'b0;
            end
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.cnt         = cnt_q;
    assign bus.duty_flat   = duty_q;
    assign bus.duty_load   = load_q;
    assign bus.all_settled = settled_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start / breathing controller for the 8-channel PWM generator. Owns the shared period counter and per-channel duty targets. Ramps each channel's live duty toward its host-written target by a bounded step every `RAMP_DIV` periods. Presents the new duty set to the generator once per update with a load strobe; the generator double-buffers it and applies it at its next period wrap.

## Interface
- `CH`, 8: number of PWM channels.
- `DW`, 8: duty/counter width; period = 2^DW clocks. Requires 2^DW ≥ CH+3.
- `RAMP_DIV`, 4: periods between ramp steps (≥1).
- `STEP`, 1: maximum duty change per ramp step (1..2^DW−1).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  run request; low forces outputs off.
- `wr_valid`  in  1  host target-write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_ch`  in  $clog2(CH)  channel index; values ≥ CH are accepted and ignored.
- `wr_target`  in  DW  target duty.
- `cnt`  out  DW  period counter, shared with the generator.
- `duty_flat`  out  CH*DW  live duties; channel k occupies bits [k*DW +: DW]. Registered.
- `duty_load`  out  1  one-cycle strobe; `duty_flat` is new in this cycle.
- `all_settled`  out  1  high when every live duty equals its target.

## Operation
- States: IDLE, RUN, SCAN, COMMIT.
- IDLE: `cnt` held at 0 and live duties held at 0. Writes are accepted. Goes to RUN when `enable` = 1.
- RUN: `cnt` increments by 1 and wraps from 2^DW−1 to 0. The divider `div` increments on each wrap. When a wrap coincides with `div == RAMP_DIV−1`, `div` clears and the next state is SCAN.
- SCAN: lasts exactly CH cycles; index `ch` runs 0..CH−1, one channel per cycle.
  - If cur < tgt: cur += min(STEP, tgt−cur).
  - If cur > tgt: cur −= min(STEP, cur−tgt).
  - Else unchanged.
  - Arithmetic is unsigned, DW bits, and never overflows or underflows.
- COMMIT: one cycle. Copies all cur values into `duty_flat` and registers `duty_load` = 1. Then returns to RUN.
- `cnt` keeps counting through SCAN and COMMIT.
- Writes:
  - `wr_ready` = (state != SCAN).
  - An accepted write updates tgt[wr_ch] at the end of that cycle.
  - A write accepted in the same cycle as the triggering wrap is used by the following SCAN.
  - Writes to a channel already scanned take effect in the next ramp step.
- `all_settled`: registered; compares committed `duty_flat` against tgt.
- `enable` low in any non-IDLE state: next state is IDLE, `cnt` ← 0, cur ← 0, `duty_flat` ← 0, and `duty_load` pulses once. Targets are retained.
- Reset values:
  - Outputs: `cnt` = 0, `duty_flat` = 0, `duty_load` = 0, `wr_ready` = 1, `all_settled` = 1.
  - Internal: tgt = 0, cur = 0, `div` = 0, state IDLE.
  - A reset mid-SCAN discards the partial update.

## Timing
- Wrap cycle is `cnt` = 2^DW−1. SCAN occupies `cnt` = 0..CH−1. COMMIT is at `cnt` = CH.
- `duty_flat` / `duty_load` are visible at `cnt` = CH+1, which is 2^DW−CH−2 cycles before the next wrap. This is the generator's load window.
- Step cadence: one update every RAMP_DIV periods. The first update follows the RAMP_DIV-th wrap after entering RUN.
- Full-scale ramp time = ceil(2^DW−1 / STEP) × RAMP_DIV periods.
- Write-to-target latency: 1 cycle. Target-to-visible-duty latency: up to RAMP_DIV periods + CH+2 cycles.

## Structure
- Package `pwm_ctrl_pkg` holds:
  - State enum `pwm_ctrl_state_t` (IDLE, RUN, SCAN, COMMIT).
  - Default constants `PWM_CH` = 8 and `PWM_DW` = 8.
- Sub-module `pwm_ramp_step` (combinational) takes (cur, tgt, STEP) and returns the next cur, with the clamped up/down rule. It is shared by the single SCAN datapath.
- Per-channel cur/tgt arrays are registers, indexed by `ch` during SCAN.

## Test plan
- Reset: `rst_n` = 0 for 3 cycles while `enable` = 1 → `cnt` = 0, `duty_flat` = 0, `duty_load` = 0, `wr_ready` = 1, `all_settled` = 1. RUN starts on the first cycle after release.
- Ramp up, RAMP_DIV=1, STEP=1: write ch0 target 4, then enable → ch0 duty reads 1, 2, 3, 4 in four consecutive periods. `duty_load` is high at `cnt` = 9 each period. `all_settled` rises after the value 4 commits.
- Clamp, STEP=3: ch5 target 5 from 0 → ch5 reads 3, then 5. A ramp down to target 0 reads 2, then 0. Other channels stay 0.
- Write during SCAN: hold `wr_valid` with ch2=200 from `cnt` = 0 → `wr_ready` is low for `cnt` 0..7. The write is accepted at `cnt` = 8, and ch2 starts ramping at the next update.
- Divider, RAMP_DIV=4: ch1 target 10 → the first `duty_load` comes after the 4th wrap. Subsequent loads are every 4 periods, each +1.
- Enable drop mid-SCAN (`cnt` = 3) → next cycle state IDLE, `cnt` = 0, `duty_flat` = 0. `duty_load` pulses once and targets are preserved. Re-enabling resumes the ramp from 0.
